// File: rtl/video_timing_pkg.sv
// Shared types and default raster constants for the video timing generator.
// Defaults describe 640x480@60 with a 2x-scaled 256x240 window centred horizontally.
package video_timing_pkg;

    typedef enum logic [1:0] {
        PH_ACTIVE,
        PH_FP,
        PH_SYNC,
        PH_BP
    } phase_e;

    localparam int DEF_CW         = 12;

    localparam int DEF_H_ACTIVE   = 640;
    localparam int DEF_H_FP       = 16;
    localparam int DEF_H_SYNC     = 96;
    localparam int DEF_H_BP       = 48;

    localparam int DEF_V_ACTIVE   = 480;
    localparam int DEF_V_FP       = 10;
    localparam int DEF_V_SYNC     = 2;
    localparam int DEF_V_BP       = 33;

    localparam int DEF_WIN_X0     = 64;
    localparam int DEF_WIN_Y0     = 0;
    localparam int DEF_WIN_W      = 256;
    localparam int DEF_WIN_H      = 240;
    localparam int DEF_SCALE_LOG2 = 1;

    // On-screen extent of a window side after upscaling.
    function automatic int scaled_span(input int src, input int scale_log2);
        return src << scale_log2;
    endfunction

endpackage

// File: rtl/video_timing_if.sv
// Bundle of raster outputs driven by video_timing_gen toward the encoder/PPU.
// master = generator side, slave = consumer side.
interface video_timing_if
    import video_timing_pkg::*;
#(
    parameter int CW = DEF_CW
);
    logic          o_hsync;
    logic          o_vsync;
    logic          o_rd;
    logic          o_newline;
    logic          o_newframe;
    logic [CW-1:0] o_x;
    logic [CW-1:0] o_y;
    logic          o_win;
    logic [8:0]    o_win_x;
    logic [8:0]    o_win_y;

    modport master (
        output o_hsync, o_vsync, o_rd, o_newline, o_newframe,
        output o_x, o_y, o_win, o_win_x, o_win_y
    );

    modport slave (
        input o_hsync, o_vsync, o_rd, o_newline, o_newframe,
        input o_x, o_y, o_win, o_win_x, o_win_y
    );
endinterface

// File: rtl/video_timing_axis.sv
// One raster axis: position counter plus ACTIVE/FP/SYNC/BP phase FSM, both advancing on step_i.
// wrap_o is combinational: high on the step that takes the counter from TOTAL-1 back to 0.
module video_timing_axis
    import video_timing_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP,
    parameter int CW     = DEF_CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          step_i,
    output logic [CW-1:0] cnt_o,
    output phase_e        phase_o,
    output logic          wrap_o
);
    localparam int TOTAL = ACTIVE + FP + SYNC + BP;

    localparam logic [CW-1:0] ACT_LAST  = CW'(ACTIVE - 1);
    localparam logic [CW-1:0] FP_LAST   = CW'(ACTIVE + FP - 1);
    localparam logic [CW-1:0] SYNC_LAST = CW'(ACTIVE + FP + SYNC - 1);
    localparam logic [CW-1:0] LAST      = CW'(TOTAL - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    phase_e        phase_q, phase_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            phase_q <= PH_ACTIVE;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    // Phase leaves its state on the last count of that phase, so it always matches cnt_q.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        wrap_o  = 1'b0;
        if (step_i) begin
            if (cnt_q == LAST) begin
                cnt_d  = '0;
                wrap_o = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            case (phase_q)
                PH_ACTIVE: if (cnt_q == ACT_LAST)  phase_d = PH_FP;
                PH_FP:     if (cnt_q == FP_LAST)   phase_d = PH_SYNC;
                PH_SYNC:   if (cnt_q == SYNC_LAST) phase_d = PH_BP;
                PH_BP:     if (cnt_q == LAST)      phase_d = PH_ACTIVE;
                default:                           phase_d = PH_ACTIVE;
            endcase
        end
    end

    assign cnt_o   = cnt_q;
    assign phase_o = phase_q;

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: syncs, data enable, line/frame strobes, coordinates, all registered.
// Optional scaled window with source coordinates when VIDEO_TIMING_WINDOW_EN is defined (tied to 0 otherwise).
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter bit HS_POL     = 1'b0,
    parameter bit VS_POL     = 1'b0,
    parameter int CW         = DEF_CW,
    parameter int WIN_X0     = DEF_WIN_X0,
    parameter int WIN_Y0     = DEF_WIN_Y0,
    parameter int WIN_W      = DEF_WIN_W,
    parameter int WIN_H      = DEF_WIN_H,
    parameter int SCALE_LOG2 = DEF_SCALE_LOG2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_en,
    video_timing_if.master vid
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int WIN_PW  = scaled_span(WIN_W, SCALE_LOG2);
    localparam int WIN_PH  = scaled_span(WIN_H, SCALE_LOG2);

    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_phase
        $error("video_timing_gen: every phase length must be at least 1");
    end
    if (H_TOTAL >= 2**CW || V_TOTAL >= 2**CW) begin : g_bad_width
        $error("video_timing_gen: CW too narrow for the raster totals");
    end
    if (WIN_X0 < 0 || WIN_Y0 < 0 || WIN_W > 512 || WIN_H > 512 ||
        WIN_X0 + WIN_PW > H_ACTIVE || WIN_Y0 + WIN_PH > V_ACTIVE) begin : g_bad_window
        $error("video_timing_gen: window does not fit the active area");
    end

    logic [CW-1:0] h_cnt, v_cnt;
    phase_e        h_ph, v_ph;
    logic          h_wrap, v_wrap;

    video_timing_axis #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .CW(CW)
    ) u_h_axis (
        .clk(clk), .rst_n(rst_n), .step_i(i_en),
        .cnt_o(h_cnt), .phase_o(h_ph), .wrap_o(h_wrap)
    );

    // The vertical axis steps once per line; its wrap is therefore the frame-end strobe.
    video_timing_axis #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .CW(CW)
    ) u_v_axis (
        .clk(clk), .rst_n(rst_n), .step_i(h_wrap),
        .cnt_o(v_cnt), .phase_o(v_ph), .wrap_o(v_wrap)
    );

    logic       rd_d, hs_d, vs_d;
    logic       win_d;
    logic [8:0] win_x_d, win_y_d;

    always_comb begin
        rd_d = (h_ph == PH_ACTIVE) && (v_ph == PH_ACTIVE);
        hs_d = (h_ph == PH_SYNC) ? HS_POL : ~HS_POL;
        vs_d = (v_ph == PH_SYNC) ? VS_POL : ~VS_POL;
    end

`ifdef VIDEO_TIMING_WINDOW_EN
    logic [CW-1:0] dx, dy;

    // Offsets below the origin wrap to huge values, so one unsigned compare covers both bounds.
    always_comb begin
        dx      = h_cnt - CW'(WIN_X0);
        dy      = v_cnt - CW'(WIN_Y0);
        win_d   = rd_d && (dx < CW'(WIN_PW)) && (dy < CW'(WIN_PH));
        win_x_d = '0;
        win_y_d = '0;
        if (win_d) begin
            win_x_d = 9'(dx >> SCALE_LOG2);
            win_y_d = 9'(dy >> SCALE_LOG2);
        end
    end
`else
    always_comb begin
        win_d   = 1'b0;
        win_x_d = '0;
        win_y_d = '0;
    end
`endif

    logic          rd_q, hs_q, vs_q, nl_q, nf_q, win_q;
    logic [CW-1:0] x_q, y_q;
    logic [8:0]    win_x_q, win_y_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_q    <= 1'b0;
            hs_q    <= ~HS_POL;
            vs_q    <= ~VS_POL;
            nl_q    <= 1'b0;
            nf_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            win_q   <= 1'b0;
            win_x_q <= '0;
            win_y_q <= '0;
        end else begin
            nl_q <= h_wrap;
            nf_q <= v_wrap;
            if (i_en) begin
                rd_q    <= rd_d;
                hs_q    <= hs_d;
                vs_q    <= vs_d;
                x_q     <= h_cnt;
                y_q     <= v_cnt;
                win_q   <= win_d;
                win_x_q <= win_x_d;
                win_y_q <= win_y_d;
            end
        end
    end

    assign vid.o_hsync    = hs_q;
    assign vid.o_vsync    = vs_q;
    assign vid.o_rd       = rd_q;
    assign vid.o_newline  = nl_q;
    assign vid.o_newframe = nf_q;
    assign vid.o_x        = x_q;
    assign vid.o_y        = y_q;
    assign vid.o_win      = win_q;
    assign vid.o_win_x    = win_x_q;
    assign vid.o_win_y    = win_y_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: default 640x480 instance plus a tiny-raster instance for frame-level behaviour.
module tb_video_timing_gen;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic en_a  = 1'b0;
    logic en_b  = 1'b0;

    always #5 clk = ~clk;

    video_timing_if va ();
    video_timing_if vb ();

    video_timing_gen dut_a (
        .clk(clk), .rst_n(rst_n), .i_en(en_a), .vid(va.master)
    );

    // 14 clocks per line, 10 lines per frame, positive syncs, 2x window at (2,1) of 2x2 source pixels.
    video_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1),
        .WIN_X0(2), .WIN_Y0(1), .WIN_W(2), .WIN_H(2), .SCALE_LOG2(1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .i_en(en_b), .vid(vb.master)
    );

`ifdef VIDEO_TIMING_WINDOW_EN
    localparam bit WIN_ON = 1'b1;
`else
    localparam bit WIN_ON = 1'b0;
`endif

    typedef struct {
        int which;
        int x, y;
        bit rd, hs, vs, nl, nf, win;
        int wx, wy;
    } vec_t;

    typedef struct {
        int x, y;
        bit rd, hs, vs, nl, nf, win;
        int wx, wy;
    } obs_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   pa = -1;
    int   pb = -1;

    function automatic vec_t mk(input int w, input int x, input int y,
                                input bit rd, input bit hs, input bit vs, input bit nl, input bit nf,
                                input bit win, input int wx, input int wy);
        vec_t v;
        v.which = w; v.x = x; v.y = y;
        v.rd = rd; v.hs = hs; v.vs = vs; v.nl = nl; v.nf = nf;
        v.win = win; v.wx = wx; v.wy = wy;
        return v;
    endfunction

    function automatic obs_t get(input int which);
        obs_t o;
        if (which == 0) begin
            o.x = int'(va.o_x); o.y = int'(va.o_y); o.rd = va.o_rd; o.hs = va.o_hsync; o.vs = va.o_vsync;
            o.nl = va.o_newline; o.nf = va.o_newframe; o.win = va.o_win;
            o.wx = int'(va.o_win_x); o.wy = int'(va.o_win_y);
        end else begin
            o.x = int'(vb.o_x); o.y = int'(vb.o_y); o.rd = vb.o_rd; o.hs = vb.o_hsync; o.vs = vb.o_vsync;
            o.nl = vb.o_newline; o.nf = vb.o_newframe; o.win = vb.o_win;
            o.wx = int'(vb.o_win_x); o.wy = int'(vb.o_win_y);
        end
        return o;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Advance one clock; sample point is 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rst_n && en_a) pa++;
        if (rst_n && en_b) pb++;
    endtask

    task automatic check_obs(input string tag, input obs_t o, input vec_t v);
        chk({tag, ".x"},      o.x,  v.x);
        chk({tag, ".y"},      o.y,  v.y);
        chk({tag, ".rd"},     int'(o.rd),  int'(v.rd));
        chk({tag, ".hsync"},  int'(o.hs),  int'(v.hs));
        chk({tag, ".vsync"},  int'(o.vs),  int'(v.vs));
        chk({tag, ".newline"},  int'(o.nl), int'(v.nl));
        chk({tag, ".newframe"}, int'(o.nf), int'(v.nf));
        chk({tag, ".win"},    int'(o.win), WIN_ON ? int'(v.win) : 0);
        chk({tag, ".win_x"},  o.wx, WIN_ON ? v.wx : 0);
        chk({tag, ".win_y"},  o.wy, WIN_ON ? v.wy : 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t o;
        int   cnt_rd, cnt_hs, first_hs_x, cnt_nl, cnt_nf, cnt_vs, first_vs_y, nl_tick, nf_tick, bad, g;

        // dut A, screen (which,x,y, rd,hs,vs,nl,nf, win,wx,wy); syncs idle high
        tbl.push_back(mk(0,   0, 0, 1, 1, 1, 0, 0, 0,   0, 0));
        tbl.push_back(mk(0,  63, 0, 1, 1, 1, 0, 0, 0,   0, 0));
        tbl.push_back(mk(0,  64, 0, 1, 1, 1, 0, 0, 1,   0, 0));
        tbl.push_back(mk(0,  65, 0, 1, 1, 1, 0, 0, 1,   0, 0));
        tbl.push_back(mk(0,  66, 0, 1, 1, 1, 0, 0, 1,   1, 0));
        tbl.push_back(mk(0, 575, 0, 1, 1, 1, 0, 0, 1, 255, 0));
        tbl.push_back(mk(0, 576, 0, 1, 1, 1, 0, 0, 0,   0, 0));
        tbl.push_back(mk(0, 639, 0, 1, 1, 1, 0, 0, 0,   0, 0));
        tbl.push_back(mk(0, 640, 0, 0, 1, 1, 0, 0, 0,   0, 0));
        tbl.push_back(mk(0, 655, 0, 0, 1, 1, 0, 0, 0,   0, 0));
        tbl.push_back(mk(0, 656, 0, 0, 0, 1, 0, 0, 0,   0, 0));
        tbl.push_back(mk(0, 751, 0, 0, 0, 1, 0, 0, 0,   0, 0));
        tbl.push_back(mk(0, 752, 0, 0, 1, 1, 0, 0, 0,   0, 0));
        tbl.push_back(mk(0, 799, 0, 0, 1, 1, 1, 0, 0,   0, 0));
        tbl.push_back(mk(0,   0, 1, 1, 1, 1, 0, 0, 0,   0, 0));
        tbl.push_back(mk(0, 100, 1, 1, 1, 1, 0, 0, 1,  18, 0));
        tbl.push_back(mk(0, 200, 3, 1, 1, 1, 0, 0, 1,  68, 1));
        // dut B, tiny raster; syncs idle low
        tbl.push_back(mk(1,   0, 0, 1, 0, 0, 0, 0, 0,   0, 0));
        tbl.push_back(mk(1,   2, 1, 1, 0, 0, 0, 0, 1,   0, 0));
        tbl.push_back(mk(1,   6, 1, 1, 0, 0, 0, 0, 0,   0, 0));
        tbl.push_back(mk(1,   7, 2, 1, 0, 0, 0, 0, 0,   0, 0));
        tbl.push_back(mk(1,   8, 2, 0, 0, 0, 0, 0, 0,   0, 0));
        tbl.push_back(mk(1,  10, 2, 0, 1, 0, 0, 0, 0,   0, 0));
        tbl.push_back(mk(1,  12, 2, 0, 1, 0, 0, 0, 0,   0, 0));
        tbl.push_back(mk(1,   4, 3, 1, 0, 0, 0, 0, 1,   1, 1));
        tbl.push_back(mk(1,   5, 4, 1, 0, 0, 0, 0, 1,   1, 1));
        tbl.push_back(mk(1,   2, 5, 1, 0, 0, 0, 0, 0,   0, 0));
        tbl.push_back(mk(1,  13, 5, 0, 0, 0, 1, 0, 0,   0, 0));
        tbl.push_back(mk(1,   0, 6, 0, 0, 0, 0, 0, 0,   0, 0));
        tbl.push_back(mk(1,   0, 7, 0, 0, 1, 0, 0, 0,   0, 0));
        tbl.push_back(mk(1,  13, 9, 0, 0, 0, 1, 1, 0,   0, 0));

        // Reset in the middle of a frame: A inside active video, B inside hsync.
        repeat (3) tick();
        rst_n = 1'b1; en_a = 1'b1; en_b = 1'b1;
        repeat (1006) tick();
        chk("pre_reset.a_rd", int'(va.o_rd), 1);
        chk("pre_reset.b_hsync", int'(vb.o_hsync), 1);
        rst_n = 1'b0;
        repeat (3) tick();
        check_obs("reset.a", get(0), mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        check_obs("reset.b", get(1), mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        rst_n = 1'b1; en_b = 1'b0; pa = -1; pb = -1;
        tick();
        o = get(0);
        chk("release.x", o.x, 0);
        chk("release.y", o.y, 0);
        chk("release.rd", int'(o.rd), 1);

        foreach (tbl[i]) begin
            int tgt;
            tgt  = tbl[i].y * (tbl[i].which == 0 ? 800 : 14) + tbl[i].x;
            en_a = (tbl[i].which == 0);
            en_b = (tbl[i].which == 1);
            g    = 0;
            while (((tbl[i].which == 0) ? pa : pb) < tgt && g < 5000) begin
                tick();
                g++;
            end
            chk($sformatf("vec%0d.reached", i), (tbl[i].which == 0) ? pa : pb, tgt);
            check_obs($sformatf("vec%0d", i), get(tbl[i].which), tbl[i]);
        end

        // One full line on A at full rate.
        en_a = 1'b1; en_b = 1'b0; g = 0;
        while (!va.o_newline && g < 2000) begin tick(); g++; end
        chk("line.sync_to_newline", int'(va.o_newline), 1);
        cnt_rd = 0; cnt_hs = 0; cnt_nl = 0; first_hs_x = -1;
        for (int t = 1; t <= 800; t++) begin
            tick();
            if (va.o_rd) cnt_rd++;
            if (!va.o_hsync) begin
                cnt_hs++;
                if (first_hs_x < 0) first_hs_x = int'(va.o_x);
            end
            if (va.o_newline) cnt_nl++;
        end
        chk("line.rd_clks", cnt_rd, 640);
        chk("line.hsync_clks", cnt_hs, 96);
        chk("line.hsync_first_x", first_hs_x, 656);
        chk("line.newline_count", cnt_nl, 1);
        chk("line.newline_at_end", int'(va.o_newline), 1);

        // Same line with i_en toggling 1/0: everything stretches 2x, strobes only after enabled edges.
        cnt_rd = 0; cnt_hs = 0; cnt_nl = 0; nl_tick = -1; bad = 0;
        for (int t = 1; t <= 1600; t++) begin
            en_a = (t % 2 == 1);
            tick();
            if (va.o_rd) cnt_rd++;
            if (!va.o_hsync) cnt_hs++;
            if (va.o_newline) begin
                cnt_nl++;
                nl_tick = t;
                if (!en_a) bad++;
            end
        end
        chk("gate.rd_clks", cnt_rd, 1280);
        chk("gate.hsync_clks", cnt_hs, 192);
        chk("gate.newline_count", cnt_nl, 1);
        chk("gate.newline_tick", nl_tick, 1599);
        chk("gate.strobe_on_idle", bad, 0);

        // Whole frame on B, starting right after its frame strobe.
        en_a = 1'b0; en_b = 1'b1;
        cnt_nl = 0; cnt_nf = 0; cnt_vs = 0; first_vs_y = -1; nf_tick = -1; bad = 0;
        for (int t = 1; t <= 140; t++) begin
            tick();
            if (t == 1) begin
                o = get(1);
                chk("frame.wrap_x", o.x, 0);
                chk("frame.wrap_y", o.y, 0);
                chk("frame.wrap_rd", int'(o.rd), 1);
            end
            if (vb.o_newline) cnt_nl++;
            if (vb.o_newframe) begin
                cnt_nf++;
                nf_tick = t;
                if (!vb.o_newline) bad++;
            end
            if (vb.o_vsync) begin
                cnt_vs++;
                if (first_vs_y < 0) first_vs_y = int'(vb.o_y);
            end
        end
        chk("frame.newline_count", cnt_nl, 10);
        chk("frame.newframe_count", cnt_nf, 1);
        chk("frame.newframe_period", nf_tick, 140);
        chk("frame.newframe_without_newline", bad, 0);
        chk("frame.vsync_clks", cnt_vs, 28);
        chk("frame.vsync_first_line", first_vs_y, 7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
